// File: rtl/ecg_pkg.sv
// Shared constants and state encoding for the ECG window feeder.
package ecg_pkg;

  localparam int BITSIZE  = 16;
  localparam int WIN      = 92;
  localparam int HOP      = 46;
  localparam int OUT_SIZE = 4;
  localparam int TIMEOUT  = 32;

  // Counter widths: the sample counter must be able to hold WIN itself.
  localparam int NEED_W = $clog2(WIN + 1);
  localparam int RUN_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    RUN     = 2'd1,
    COLLECT = 2'd2
  } state_t;

endpackage

// File: rtl/ecg_sample_shifter.sv
// Window shift register: word 0 is the oldest sample, new samples enter at
// the top word, and a synchronous clear empties the whole window.
module ecg_sample_shifter #(
  parameter int BITSIZE = 16,
  parameter int WIN     = 92
) (
  input  logic                   clk,
  input  logic                   i_clear,
  input  logic                   i_shift,
  input  logic [BITSIZE-1:0]     i_data,
  output logic [BITSIZE*WIN-1:0] o_x
);

  logic [BITSIZE*WIN-1:0] r_x;

  // Shift one word toward word 0 on every accepted sample; clear wins.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_x <= '0;
    end else if (i_shift) begin
      r_x <= {i_data, r_x[BITSIZE*WIN-1:BITSIZE]};
    end
  end

  assign o_x = r_x;

endmodule

// File: rtl/ecg_window_feeder.sv
// Collects ECG samples into a sliding window, runs the encoder on each full
// window by releasing its reset, and hands the latent vector downstream.
module ecg_window_feeder
  import ecg_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [BITSIZE-1:0]           s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [BITSIZE*WIN-1:0]       x,
  output logic                         enc_rst,
  input  logic                         enc_done,
  input  logic [BITSIZE*OUT_SIZE-1:0]  enc_y,
  output logic [BITSIZE*OUT_SIZE-1:0]  y_out,
  output logic                         y_valid,
  input  logic                         y_ready,
  output logic [15:0]                  win_idx,
  output logic                         err
);

  state_t                        r_state;
  state_t                        w_nextState;
  logic [NEED_W-1:0]             r_needCnt;
  logic [NEED_W-1:0]             w_need;
  logic                          r_firstWin;
  logic [RUN_W-1:0]              r_runCnt;
  logic [BITSIZE*OUT_SIZE-1:0]   r_yOut;
  logic                          r_yValid;
  logic [15:0]                   r_winIdx;
  logic                          r_err;
  logic                          r_encRst;
  logic                          w_accept;
  logic                          w_windowFull;
  logic                          w_timeout;
  logic                          w_handshake;

  // Samples are taken only in FILL; the reset gate keeps s_ready low while
  // reset is asserted even though the state register already reads FILL.
  assign s_ready      = (r_state == FILL) && !reset;
  assign w_accept     = s_valid && s_ready;
  assign w_need       = r_firstWin ? NEED_W'(WIN) : NEED_W'(HOP);
  assign w_windowFull = w_accept && ((r_needCnt + NEED_W'(1)) == w_need);
  assign w_timeout    = (r_state == RUN) && !enc_done &&
                        (r_runCnt == RUN_W'(TIMEOUT - 1));
  assign w_handshake  = (r_state == COLLECT) && r_yValid && y_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode; enc_done takes priority over the timeout in RUN.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FILL:    if (w_windowFull) w_nextState = RUN;
      RUN: begin
        if (enc_done) begin
          w_nextState = COLLECT;
        end else if (w_timeout) begin
          w_nextState = FILL;
        end
      end
      COLLECT: if (w_handshake) w_nextState = FILL;
      default: w_nextState = FILL;
    endcase
  end

  // Sample and run counters; after the first full window only HOP new
  // samples are needed because the older ones stay in the shifter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_needCnt  <= '0;
      r_firstWin <= 1'b1;
      r_runCnt   <= '0;
    end else begin
      if (w_windowFull) begin
        r_needCnt  <= '0;
        r_firstWin <= 1'b0;
        r_runCnt   <= '0;
      end else if (w_accept) begin
        r_needCnt <= r_needCnt + NEED_W'(1);
      end
      if (r_state == RUN) begin
        r_runCnt <= r_runCnt + RUN_W'(1);
      end
    end
  end

  // Registered outputs: encoder reset follows the next state so it drops on
  // the edge that enters RUN, and the latent is captured when done is seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_yOut   <= '0;
      r_yValid <= 1'b0;
      r_winIdx <= '0;
      r_err    <= 1'b0;
      r_encRst <= 1'b1;
    end else begin
      r_encRst <= (w_nextState != RUN);
      if ((r_state == RUN) && enc_done) begin
        r_yOut   <= enc_y;
        r_yValid <= 1'b1;
      end
      if (w_timeout) begin
        r_err    <= 1'b1;
        r_winIdx <= r_winIdx + 16'd1;
      end
      if (w_handshake) begin
        r_yValid <= 1'b0;
        r_winIdx <= r_winIdx + 16'd1;
      end
    end
  end

  ecg_sample_shifter #(
    .BITSIZE(BITSIZE),
    .WIN    (WIN)
  ) u_shifter (
    .clk    (clk),
    .i_clear(reset),
    .i_shift(w_accept),
    .i_data (s_data),
    .o_x    (x)
  );

  assign y_out   = r_yOut;
  assign y_valid = r_yValid;
  assign win_idx = r_winIdx;
  assign err     = r_err;
  assign enc_rst = r_encRst;

endmodule

// File: tb/tb_ecg_window_feeder.sv
// Bench for ecg_window_feeder: a stub encoder plus a queue of every accepted
// sample; the expected window is simply the newest WIN entries of that queue.
module tb_ecg_window_feeder;
  import ecg_pkg::*;

  localparam int XW = BITSIZE * WIN;
  localparam int YW = BITSIZE * OUT_SIZE;

  logic               clk = 1'b0;
  logic               reset;
  logic [BITSIZE-1:0] s_data;
  logic               s_valid;
  logic               s_ready;
  logic [XW-1:0]      x;
  logic               enc_rst;
  logic               enc_done = 1'b0;
  logic [YW-1:0]      stubY;
  logic [YW-1:0]      y_out;
  logic               y_valid;
  logic               y_ready;
  logic [15:0]        win_idx;
  logic               err;

  int compared   = 0;
  int mismatched = 0;
  int expWinIdx  = 0;
  int nextSeq    = 1;
  int encRstFalls = 0;
  logic [BITSIZE-1:0] accQ[$];

  int stubCnt  = 0;
  int stubLat  = 6;
  bit stubHang = 1'b0;

  ecg_window_feeder dut (
    .clk     (clk),
    .reset   (reset),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .x       (x),
    .enc_rst (enc_rst),
    .enc_done(enc_done),
    .enc_y   (stubY),
    .y_out   (y_out),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .win_idx (win_idx),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Stub encoder: raises done stubLat cycles after its reset is released.
  always @(posedge clk) begin
    if (enc_rst) begin
      stubCnt  <= 0;
      enc_done <= 1'b0;
    end else begin
      stubCnt <= stubCnt + 1;
      if (!stubHang && stubCnt == stubLat - 1) enc_done <= 1'b1;
    end
  end

  // Counts encoder reset releases.
  always @(negedge enc_rst) encRstFalls++;

  // Hard stop in case something stalls outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "[TB] watchdog");
  end

  // Expected window word i: the newest WIN accepted samples, word 0 oldest.
  function automatic logic [BITSIZE-1:0] expWord(input int i);
    int idx;
    idx = accQ.size() - WIN + i;
    if (idx < 0) return '0;
    return accQ[idx];
  endfunction

  function automatic int firstBadWord();
    for (int i = 0; i < WIN; i++) begin
      if (x[i*BITSIZE +: BITSIZE] !== expWord(i)) return i;
    end
    return -1;
  endfunction

  // Offer n samples, optionally with random gaps and random data.
  task automatic feed(input int n, input int validPct, input bit randData);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      s_valid = ($urandom_range(0, 99) < validPct);
      s_data  = randData ? BITSIZE'($urandom) : BITSIZE'(nextSeq);
      if (s_valid && s_ready) begin
        accQ.push_back(s_data);
        got++;
        if (!randData) nextSeq++;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    compared++;
    if (got != n) begin
      mismatched++;
      $display("[TB] FAIL feed_budget: accepted %0d, required %0d", got, n);
    end
  endtask

  // Wait for y_valid, noting whether s_ready ever rose meanwhile.
  task automatic waitValid(output int cyc, output bit readyLeak);
    cyc = 0;
    readyLeak = 1'b0;
    while (!y_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (s_ready) readyLeak = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b0; s_data = '0; y_ready = 1'b0;
    stubY = '0; stubLat = 6; stubHang = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (s_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_s_ready: got %b, required 0", s_ready); end
    compared++;
    if (enc_rst !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_enc_rst: got %b, required 1", enc_rst); end
    compared++;
    if ({y_valid, err, win_idx} !== 18'd0) begin mismatched++; $display("[TB] FAIL reset_flags: valid=%b err=%b idx=%0d, required zeros", y_valid, err, win_idx); end
    compared++;
    if (x !== '0 || y_out !== '0) begin mismatched++; $display("[TB] FAIL reset_data: x or y_out nonzero, required zero"); end
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (s_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL post_reset_s_ready: got %b, required 1", s_ready); end
  endtask

  task automatic test_first_window();
    int cyc; bit leak; int bad; int falls0;
    stubY = 64'h0004_0003_0002_0001; stubLat = 6; y_ready = 1'b0;
    falls0 = encRstFalls;
    feed(WIN, 100, 1'b0);
    compared++;
    if (enc_rst !== 1'b0) begin mismatched++; $display("[TB] FAIL first_enc_rst: got %b, required 0", enc_rst); end
    compared++;
    if (x[BITSIZE-1:0] !== 16'd1) begin mismatched++; $display("[TB] FAIL first_word0: got %0d, required 1", x[BITSIZE-1:0]); end
    compared++;
    if (x[XW-1 -: BITSIZE] !== 16'd92) begin mismatched++; $display("[TB] FAIL first_word91: got %0d, required 92", x[XW-1 -: BITSIZE]); end
    bad = firstBadWord();
    compared++;
    if (bad >= 0) begin mismatched++; $display("[TB] FAIL first_window: word %0d is %h, required %h", bad, x[bad*BITSIZE +: BITSIZE], expWord(bad)); end
    waitValid(cyc, leak);
    compared++;
    if (cyc != stubLat + 1) begin mismatched++; $display("[TB] FAIL first_latency: y_valid after %0d cycles, required %0d", cyc, stubLat + 1); end
    compared++;
    if (leak) begin mismatched++; $display("[TB] FAIL first_s_ready: got 1 during RUN, required 0"); end
    compared++;
    if (y_out !== stubY) begin mismatched++; $display("[TB] FAIL first_y_out: got %h, required %h", y_out, stubY); end
    compared++;
    if (win_idx !== 16'(expWinIdx)) begin mismatched++; $display("[TB] FAIL first_win_idx: got %0d, required %0d", win_idx, expWinIdx); end
    compared++;
    if (encRstFalls - falls0 != 1) begin mismatched++; $display("[TB] FAIL first_enc_rst_falls: got %0d, required 1", encRstFalls - falls0); end
  endtask

  task automatic test_backpressure();
    logic [YW-1:0] yHold; bit unstable;
    yHold = y_out;
    unstable = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (y_valid !== 1'b1 || y_out !== yHold || s_ready !== 1'b0) unstable = 1'b1;
    end
    compared++;
    if (unstable) begin mismatched++; $display("[TB] FAIL hold_stable: valid=%b y_out=%h ready=%b, required 1/%h/0", y_valid, y_out, s_ready, yHold); end
    y_ready = 1'b1;
    @(negedge clk);
    expWinIdx++;
    compared++;
    if (y_valid !== 1'b0 || s_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL hold_release: valid=%b ready=%b, required 0/1", y_valid, s_ready); end
    compared++;
    if (win_idx !== 16'(expWinIdx)) begin mismatched++; $display("[TB] FAIL hold_win_idx: got %0d, required %0d", win_idx, expWinIdx); end
  endtask

  task automatic test_stream_ready();
    int cyc; bit leak; int bad;
    stubY = 64'h0008_0007_0006_0005;
    feed(HOP, 100, 1'b0);
    compared++;
    if (x[BITSIZE-1:0] !== 16'd47 || x[XW-1 -: BITSIZE] !== 16'd138) begin mismatched++; $display("[TB] FAIL second_ends: word0=%0d word91=%0d, required 47/138", x[BITSIZE-1:0], x[XW-1 -: BITSIZE]); end
    bad = firstBadWord();
    compared++;
    if (bad >= 0) begin mismatched++; $display("[TB] FAIL second_window: word %0d is %h, required %h", bad, x[bad*BITSIZE +: BITSIZE], expWord(bad)); end
    waitValid(cyc, leak);
    compared++;
    if (leak || s_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL second_s_ready: leak=%b now=%b, required 0", leak, s_ready); end
    compared++;
    if (y_valid !== 1'b1 || y_out !== stubY || win_idx !== 16'(expWinIdx)) begin mismatched++; $display("[TB] FAIL second_latent: valid=%b y=%h idx=%0d, required 1/%h/%0d", y_valid, y_out, win_idx, stubY, expWinIdx); end
    @(negedge clk);
    expWinIdx++;
    compared++;
    if (y_valid !== 1'b0 || s_ready !== 1'b1 || win_idx !== 16'(expWinIdx)) begin mismatched++; $display("[TB] FAIL second_handshake: valid=%b ready=%b idx=%0d, required 0/1/%0d", y_valid, s_ready, win_idx, expWinIdx); end
  endtask

  task automatic test_timeout();
    int k; bit sawV; int cyc; bit leak; int bad;
    stubHang = 1'b1;
    feed(HOP, 100, 1'b1);
    k = 0;
    sawV = 1'b0;
    while (!err && k < 100) begin
      @(negedge clk);
      k++;
      if (y_valid) sawV = 1'b1;
    end
    expWinIdx++;
    compared++;
    if (k != TIMEOUT) begin mismatched++; $display("[TB] FAIL timeout_cycles: err after %0d cycles, required %0d", k, TIMEOUT); end
    compared++;
    if (sawV) begin mismatched++; $display("[TB] FAIL timeout_no_latent: y_valid rose, required 0"); end
    compared++;
    if (win_idx !== 16'(expWinIdx) || s_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL timeout_recover: idx=%0d ready=%b, required %0d/1", win_idx, s_ready, expWinIdx); end
    stubHang = 1'b0;
    stubLat = $urandom_range(1, 20);
    stubY = {$urandom, $urandom};
    feed(HOP - 1, 100, 1'b1);
    compared++;
    if (enc_rst !== 1'b1 || s_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL timeout_hop_short: enc_rst=%b ready=%b, required 1/1", enc_rst, s_ready); end
    feed(1, 100, 1'b1);
    compared++;
    if (enc_rst !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_hop_run: enc_rst=%b, required 0", enc_rst); end
    bad = firstBadWord();
    compared++;
    if (bad >= 0) begin mismatched++; $display("[TB] FAIL timeout_window: word %0d is %h, required %h", bad, x[bad*BITSIZE +: BITSIZE], expWord(bad)); end
    waitValid(cyc, leak);
    compared++;
    if (cyc != stubLat + 1 || y_out !== stubY || err !== 1'b1) begin mismatched++; $display("[TB] FAIL timeout_next_latent: cyc=%0d y=%h err=%b, required %0d/%h/1", cyc, y_out, err, stubLat + 1, stubY); end
    @(negedge clk);
    expWinIdx++;
    compared++;
    if (win_idx !== 16'(expWinIdx)) begin mismatched++; $display("[TB] FAIL timeout_next_idx: got %0d, required %0d", win_idx, expWinIdx); end
  endtask

  task automatic test_reset_mid_run();
    int cyc; bit leak; int bad;
    stubLat = 6;
    stubY = {$urandom, $urandom};
    feed(HOP, 100, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if (s_ready !== 1'b0 || enc_rst !== 1'b1) begin mismatched++; $display("[TB] FAIL midrun_ctrl: ready=%b enc_rst=%b, required 0/1", s_ready, enc_rst); end
    compared++;
    if (x !== '0 || y_out !== '0 || {y_valid, err, win_idx} !== 18'd0) begin mismatched++; $display("[TB] FAIL midrun_clear: valid=%b err=%b idx=%0d, required all zero", y_valid, err, win_idx); end
    reset = 1'b0;
    accQ.delete();
    expWinIdx = 0;
    @(negedge clk);
    compared++;
    if (s_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL midrun_s_ready: got %b, required 1", s_ready); end
    feed(WIN - 1, 100, 1'b1);
    compared++;
    if (enc_rst !== 1'b1) begin mismatched++; $display("[TB] FAIL midrun_full_needed: enc_rst=%b after %0d samples, required 1", enc_rst, WIN - 1); end
    feed(1, 100, 1'b1);
    bad = firstBadWord();
    compared++;
    if (enc_rst !== 1'b0 || bad >= 0) begin mismatched++; $display("[TB] FAIL midrun_window: enc_rst=%b bad word %0d, required 0/-1", enc_rst, bad); end
    waitValid(cyc, leak);
    compared++;
    if (y_out !== stubY || win_idx !== 16'd0) begin mismatched++; $display("[TB] FAIL midrun_latent: y=%h idx=%0d, required %h/0", y_out, win_idx, stubY); end
    @(negedge clk);
    expWinIdx++;
    compared++;
    if (win_idx !== 16'(expWinIdx)) begin mismatched++; $display("[TB] FAIL midrun_idx: got %0d, required %0d", win_idx, expWinIdx); end
  endtask

  task automatic test_random_valid();
    int cyc; bit leak; int bad; int hold;
    for (int w = 0; w < 4; w++) begin
      stubLat = $urandom_range(1, 20);
      stubY = {$urandom, $urandom};
      y_ready = 1'b0;
      feed(HOP, 50, 1'b1);
      bad = firstBadWord();
      compared++;
      if (bad >= 0) begin mismatched++; $display("[TB] FAIL rand_window%0d: word %0d is %h, required %h", w, bad, x[bad*BITSIZE +: BITSIZE], expWord(bad)); end
      waitValid(cyc, leak);
      compared++;
      if (cyc != stubLat + 1 || leak || y_out !== stubY) begin mismatched++; $display("[TB] FAIL rand_latent%0d: cyc=%0d leak=%b y=%h, required %0d/0/%h", w, cyc, leak, y_out, stubLat + 1, stubY); end
      hold = $urandom_range(0, 5);
      repeat (hold) @(negedge clk);
      y_ready = 1'b1;
      @(negedge clk);
      expWinIdx++;
      compared++;
      if (y_valid !== 1'b0 || win_idx !== 16'(expWinIdx)) begin mismatched++; $display("[TB] FAIL rand_handshake%0d: valid=%b idx=%0d, required 0/%0d", w, y_valid, win_idx, expWinIdx); end
    end
  endtask

  // Scenario sequence.
  initial begin
    $display("[TB] starting ecg_window_feeder bench");
    test_reset();
    test_first_window();
    test_backpressure();
    test_stream_ready();
    test_timeout();
    test_reset_mid_run();
    test_random_valid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
